// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RISC-V controller: ISA encodings, datapath
// select enums and the controller state encoding.
package multicycle_ctrl_pkg;

    localparam int OPCODE_WIDTH = 7;
    localparam int ALU_WIDTH    = 3;
    localparam int IMM_WIDTH    = 3;
    localparam int DATA_WIDTH   = 32;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_LOAD   = 7'b0000011,
        OP_ADDI   = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    typedef enum logic [ALU_WIDTH-1:0] {
        SUM_OP = 3'd0,
        SUB_OP = 3'd1,
        AND_OP = 3'd2,
        OR_OP  = 3'd3,
        XOR_OP = 3'd4,
        SLT_OP = 3'd5
    } alu_ctrl_t;

    typedef enum logic [IMM_WIDTH-1:0] {
        Imm    = 3'd0,
        Store  = 3'd1,
        Branch = 3'd2,
        Upper  = 3'd3,
        Jump   = 3'd4
    } instr_format_t;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_I = 4'd2,
        ADDR   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB_ALU = 4'd6,
        WB_MEM = 4'd7,
        EXEC_B = 4'd8,
        HALT   = 4'd9
    } ctrl_state_t;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic {
        ADDR_PC  = 1'b0,
        ADDR_ALU = 1'b1
    } addr_sel_t;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_src_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller (master) and the
// datapath plus shared memory port (slave).
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [2:0]              funct3;
    logic                    zero;
    logic                    mem_ack;
    logic                    mem_req;
    logic                    mem_we;
    addr_sel_t               addr_sel;
    logic                    ir_write;
    logic                    pc_write;
    logic                    pc_src;
    logic                    alu_src_b;
    alu_ctrl_t               alu_ctrl;
    instr_format_t           imm_src;
    logic                    reg_write;
    result_src_t             result_src;
    logic                    retire;
    logic                    illegal;
    logic [DATA_WIDTH-1:0]   instret;

    modport master (
        input  opcode, funct3, zero, mem_ack,
        output mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_b, alu_ctrl, imm_src, reg_write, result_src,
               retire, illegal, instret
    );

    modport slave (
        output opcode, funct3, zero, mem_ack,
        input  mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src,
               alu_src_b, alu_ctrl, imm_src, reg_write, result_src,
               retire, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl_instr_class_decoder.sv
// Classifies the IR opcode/funct3 into the four supported instructions; any
// other encoding is flagged illegal.
module instr_class_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              funct3,
    output logic                    is_addi,
    output logic                    is_load,
    output logic                    is_store,
    output logic                    is_bne,
    output logic                    is_illegal
);

    // Opcode/funct3 classification; exactly one flag is high.
    always_comb begin
        is_addi    = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_bne     = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADDI: begin
                if (funct3 == F3_ADDI) is_addi = 1'b1;
                else                   is_illegal = 1'b1;
            end
            OP_LOAD: begin
                if (funct3 == F3_WORD) is_load = 1'b1;
                else                   is_illegal = 1'b1;
            end
            OP_STORE: begin
                if (funct3 == F3_WORD) is_store = 1'b1;
                else                   is_illegal = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BNE) is_bne = 1'b1;
                else                  is_illegal = 1'b1;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a single-ported RISC-V datapath executing
// addi, bne, lw and sw, with a retired-instruction counter and illegal trap.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    ctrl_state_t           state_r;
    ctrl_state_t           next_state_s;
    logic                  illegal_r;
    logic [DATA_WIDTH-1:0] instret_r;
    logic                  is_addi_s;
    logic                  is_load_s;
    logic                  is_store_s;
    logic                  is_bne_s;
    logic                  is_illegal_s;

    instr_class_decoder u_decoder (
        .opcode     (bus.opcode),
        .funct3     (bus.funct3),
        .is_addi    (is_addi_s),
        .is_load    (is_load_s),
        .is_store   (is_store_s),
        .is_bne     (is_bne_s),
        .is_illegal (is_illegal_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= FETCH;
        else     state_r <= next_state_s;
    end

    // Sticky trap flag, set on the edge that enters HALT.
    always_ff @(posedge clk) begin
        if (rst)                                          illegal_r <= 1'b0;
        else if (state_r != HALT && next_state_s == HALT) illegal_r <= 1'b1;
        else                                              illegal_r <= illegal_r;
    end

    // Retired-instruction counter; wraps naturally at the top of its range.
    always_ff @(posedge clk) begin
        if (rst)             instret_r <= {DATA_WIDTH{1'b0}};
        else if (bus.retire) instret_r <= instret_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        else                 instret_r <= instret_r;
    end

    assign bus.illegal = illegal_r & ~rst;
    assign bus.instret = rst ? {DATA_WIDTH{1'b0}} : instret_r;

    // Next-state and datapath strobes; everything idles while rst is high.
    always_comb begin
        next_state_s   = state_r;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.addr_sel   = ADDR_PC;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.alu_ctrl   = SUM_OP;
        bus.imm_src    = Imm;
        bus.reg_write  = 1'b0;
        bus.result_src = RES_ALU;
        bus.retire     = 1'b0;
        if (rst) begin
            next_state_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ack) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        next_state_s = DECODE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end
                DECODE: begin
                    if (is_addi_s)                    next_state_s = EXEC_I;
                    else if (is_load_s || is_store_s) next_state_s = ADDR;
                    else if (is_bne_s)                next_state_s = EXEC_B;
                    else                              next_state_s = HALT;
                end
                EXEC_I: begin
                    bus.alu_src_b = 1'b1;
                    next_state_s  = WB_ALU;
                end
                WB_ALU: begin
                    bus.reg_write = 1'b1;
                    bus.retire    = 1'b1;
                    next_state_s  = FETCH;
                end
                ADDR: begin
                    bus.alu_src_b = 1'b1;
                    // IR still holds the instruction, so the decoder tells lw from sw.
                    if (is_store_s) begin
                        bus.imm_src  = Store;
                        next_state_s = MEM_WR;
                    end else begin
                        next_state_s = MEM_RD;
                    end
                end
                MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = ADDR_ALU;
                    if (bus.mem_ack) next_state_s = WB_MEM;
                    else             next_state_s = MEM_RD;
                end
                WB_MEM: begin
                    bus.reg_write  = 1'b1;
                    bus.result_src = RES_MEM;
                    bus.retire     = 1'b1;
                    next_state_s   = FETCH;
                end
                MEM_WR: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_we   = 1'b1;
                    bus.addr_sel = ADDR_ALU;
                    if (bus.mem_ack) begin
                        bus.retire   = 1'b1;
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = MEM_WR;
                    end
                end
                EXEC_B: begin
                    bus.alu_ctrl = SUB_OP;
                    bus.imm_src  = Branch;
                    if (!bus.zero) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 1'b1;
                    end else begin
                        bus.pc_write = 1'b0;
                    end
                    bus.retire   = 1'b1;
                    next_state_s = FETCH;
                end
                HALT: begin
                    next_state_s = HALT;
                end
                default: begin
                    next_state_s = HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from an
// ISA-level timing model, checked by an independent per-cycle monitor.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int lat; int irw; int seq; int rw; int redir; int we;
        int dmem; int st; int sub; int br; int rs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_cnt;
    bit          pend;
    logic [31:0] pend_cnt;
    int a_cyc, a_irw, a_seq, a_rw, a_redir, a_we, a_dmem, a_st, a_sub, a_br, a_rs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ISA-level classification: 0 addi, 1 lw, 2 sw, 3 bne, 4 illegal.
    function automatic int kind_of(input logic [31:0] ins);
        if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) return 0;
        if (ins[6:0] == 7'h03 && ins[14:12] == 3'd2) return 1;
        if (ins[6:0] == 7'h23 && ins[14:12] == 3'd2) return 2;
        if (ins[6:0] == 7'h63 && ins[14:12] == 3'd1) return 3;
        return 4;
    endfunction

    task automatic push_expect(input logic [31:0] ins, input int fw, input int mw, input logic z);
        exp_t e;
        int k;
        k = kind_of(ins);
        case (k)
            0:       e.lat = 4 + fw;
            1:       e.lat = 5 + fw + mw;
            2:       e.lat = 4 + fw + mw;
            default: e.lat = 3 + fw;
        endcase
        e.irw   = 1;
        e.seq   = 1;
        e.rw    = (k == 0 || k == 1) ? 1 : 0;
        e.redir = (k == 3 && !z) ? 1 : 0;
        e.we    = (k == 2) ? mw + 1 : 0;
        e.dmem  = (k == 1 || k == 2) ? mw + 1 : 0;
        e.st    = (k == 2) ? 1 : 0;
        e.sub   = (k == 3) ? 1 : 0;
        e.br    = (k == 3) ? 1 : 0;
        e.rs    = (k == 1) ? 1 : 0;
        model_cnt = model_cnt + 32'd1;
        e.cnt   = model_cnt;
        sb_q.push_back(e);
    endtask

    task automatic clear_acc();
        a_cyc = 0; a_irw = 0; a_seq = 0; a_rw = 0; a_redir = 0; a_we = 0;
        a_dmem = 0; a_st = 0; a_sub = 0; a_br = 0; a_rs = 0;
    endtask

    // Monitor: accumulates what the DUT did per instruction, compares on retire.
    always @(negedge clk) begin
        if (!mon_en) begin
            clear_acc();
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("instret", bus.instret, pend_cnt);
                pend = 1'b0;
            end
            chk("pcw_and_rw", bus.pc_write & bus.reg_write, 0);
            chk("we_without_req", bus.mem_we & ~bus.mem_req, 0);
            a_cyc++;
            if (bus.ir_write)                        a_irw++;
            if (bus.pc_write && !bus.pc_src)         a_seq++;
            if (bus.pc_write && bus.pc_src)          a_redir++;
            if (bus.reg_write)                       a_rw++;
            if (bus.mem_we)                          a_we++;
            if (bus.mem_req && bus.addr_sel == ADDR_ALU) a_dmem++;
            if (bus.imm_src == Store)                a_st++;
            if (bus.alu_ctrl == SUB_OP)              a_sub++;
            if (bus.imm_src == Branch)               a_br++;
            if (bus.result_src == RES_MEM)           a_rs++;
            if (bus.retire) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("latency", a_cyc, mon_e.lat);
                    chk("ir_write_cnt", a_irw, mon_e.irw);
                    chk("pc_seq_cnt", a_seq, mon_e.seq);
                    chk("pc_branch_cnt", a_redir, mon_e.redir);
                    chk("reg_write_cnt", a_rw, mon_e.rw);
                    chk("mem_we_cnt", a_we, mon_e.we);
                    chk("data_req_cnt", a_dmem, mon_e.dmem);
                    chk("imm_store_cnt", a_st, mon_e.st);
                    chk("alu_sub_cnt", a_sub, mon_e.sub);
                    chk("imm_branch_cnt", a_br, mon_e.br);
                    chk("result_mem_cnt", a_rs, mon_e.rs);
                    pend     = 1'b1;
                    pend_cnt = mon_e.cnt;
                end
                clear_acc();
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic mem_phase(input int w);
        for (int i = 0; i <= w; i++) begin
            bus.mem_ack = (i == w);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
        int k;
        k = kind_of(ins);
        push_expect(ins, fw, mw, z);
        mem_phase(fw);
        bus.opcode = ins[6:0];
        bus.funct3 = ins[14:12];
        bus.zero   = z;
        idle(1);
        case (k)
            0:       idle(2);
            1:       begin idle(1); mem_phase(mw); idle(1); end
            2:       begin idle(1); mem_phase(mw); end
            default: idle(1);
        endcase
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 32'd0;
    endtask

    task automatic end_phase(input string name);
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk(name, sb_q.size(), 0);
    endtask

    task automatic illegal_test(input logic [31:0] ins);
        do_reset();
        mem_phase(0);
        bus.opcode = ins[6:0];
        bus.funct3 = ins[14:12];
        idle(1);
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_illegal", bus.illegal, 1);
            chk("halt_mem_req", bus.mem_req, 0);
            chk("halt_retire", bus.retire, 0);
            chk("halt_instret", bus.instret, 0);
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("halt_exit_illegal", bus.illegal, 0);
        chk("halt_exit_req", bus.mem_req, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ins;
        int k;
        rst = 1'b1;
        bus.mem_ack = 1'b0;
        bus.opcode  = 7'd0;
        bus.funct3  = 3'd0;
        bus.zero    = 1'b0;
        model_cnt   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset held 3 cycles while a load waits for its data ack.
        mem_phase(0);
        bus.opcode = 7'h03; bus.funct3 = 3'd2;
        idle(2);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("mem_rd_req", {bus.mem_req, bus.addr_sel}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outputs", {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_write,
                bus.pc_write, bus.pc_src, bus.alu_src_b, bus.alu_ctrl, bus.imm_src,
                bus.reg_write, bus.result_src, bus.retire, bus.illegal}, 0);
            chk("rst_instret", bus.instret, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        model_cnt = 32'd0;
        @(negedge clk);
        chk("post_rst_fetch", {bus.mem_req, bus.addr_sel, bus.ir_write}, 3'b100);
        chk("post_rst_instret", bus.instret, 0);
        @(posedge clk); #1;

        // Directed instruction sequence.
        do_reset();
        mon_en = 1'b1;
        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h00402103, 0, 3, 1'b0);
        run_instr(32'h00202423, 0, 0, 1'b0);
        run_instr(32'hFE009CE3, 0, 0, 1'b0);
        run_instr(32'hFE009CE3, 0, 0, 1'b1);
        end_phase("sb_drain_directed");

        illegal_test(32'h00000033);
        illegal_test(32'h00101093);

        // Counter wrap from a preloaded value.
        do_reset();
        force dut.instret_r = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.instret_r;
        @(posedge clk); #1;
        model_cnt = 32'hFFFF_FFFE;
        mon_en = 1'b1;
        run_instr(32'h00500093, 0, 0, 1'b0);
        run_instr(32'h00100113, 1, 0, 1'b0);
        end_phase("sb_drain_wrap");

        // Randomized instruction mix with random memory wait states.
        do_reset();
        mon_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            ins = $urandom;
            k = $urandom_range(0, 3);
            case (k)
                0:       begin ins[6:0] = 7'h13; ins[14:12] = 3'd0; end
                1:       begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
                2:       begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
                default: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
            endcase
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        end_phase("sb_drain_random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the single-ported RISC-V datapath: the PC, IR, register file, ALU, immediate extender and one shared instruction/data memory port.
- Executes addi, bne, lw and sw.
- Generates every datapath strobe and mux select, and drives a req/ack memory handshake.
- Keeps a retired-instruction counter.
- Traps illegal encodings into a sticky halt.

Parameters:
OPCODE_WIDTH, 7, opcode field width
ALU_WIDTH, 3, ALU command width
IMM_WIDTH, 3, immediate-format select width
DATA_WIDTH, 32, instret counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_WIDTH  IR[6:0]
funct3  in  3  IR[14:12]
zero  in  1  ALU zero flag
mem_ack  in  1  memory completes current request
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, valid with mem_req
addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  1  0 = PC+4, 1 = branch target (old_pc+imm)
alu_src_b  out  1  0 = rs2, 1 = immediate
alu_ctrl  out  ALU_WIDTH  alu_ctrl enum
imm_src  out  IMM_WIDTH  instr_format enum
reg_write  out  1  register-file write strobe
result_src  out  1  0 = ALU, 1 = memory data
retire  out  1  one-cycle pulse per completed instruction
illegal  out  1  sticky trap flag
instret  out  DATA_WIDTH  retired-instruction count

Behaviour:
- State register is clocked. Outputs are combinational from state, plus mem_ack and zero where noted.
- While rst is high, every output is forced to 0. On the edge where rst is sampled high: state <= FETCH, illegal <= 0, instret <= 0.
- Unlisted outputs are 0 in every state. alu_ctrl defaults to SUM_OP and imm_src defaults to Imm.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ack: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify from registered opcode/funct3.
  - addi with funct3 000 -> EXEC_I.
  - lw with funct3 010, or sw with funct3 010 -> ADDR.
  - bne with funct3 001 -> EXEC_B.
  - Anything else -> HALT.
- EXEC_I: alu_src_b=1, imm_src=Imm, alu_ctrl=SUM_OP -> WB_ALU.
- WB_ALU: reg_write=1, result_src=0, retire=1 -> FETCH.
- ADDR:
  - alu_src_b=1, alu_ctrl=SUM_OP.
  - imm_src=Imm for lw, Store for sw.
  - -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ack -> WB_MEM.
- WB_MEM: reg_write=1, result_src=1, retire=1 -> FETCH.
- MEM_WR:
  - mem_req=1, mem_we=1, addr_sel=1.
  - On mem_ack: retire=1, then -> FETCH.
- EXEC_B:
  - alu_src_b=0, alu_ctrl=SUB_OP, imm_src=Branch.
  - If zero==0: pc_write=1, pc_src=1.
  - retire=1 -> FETCH.
- HALT:
  - Absorbing; only rst exits.
  - illegal=1, sticky (set on the DECODE->HALT edge).
  - No strobes asserted.
- Handshake:
  - mem_ack is honoured only while mem_req=1; ack in any other state is ignored.
  - Zero-wait ack (same cycle as req) is legal.
  - mem_req stays high with a stable address and write-enable until ack.
- Latency with zero-wait memory: addi 4, lw 5, sw 4, bne 3 cycles. Each wait cycle adds 1.
- instret: increments on every retire and wraps from 0xFFFFFFFF to 0.
- Reset mid-request: mem_req drops in the reset cycle. Memory must abandon any outstanding transaction. No retire, PC or IR update occurs.
- pc_write and reg_write are never high in the same cycle. mem_we implies mem_req.

Decomposition:
- Add to types_pkg:
  - ctrl_state enum, 4 bits: FETCH, DECODE, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, EXEC_B, HALT.
  - F3_ADDI=3'b000, F3_BNE=3'b001, F3_WORD=3'b010.
  - addr_sel_t and result_src_t enums.
- Reuse the existing opcode, alu_ctrl and instr_format enums.
- One sub-module, instr_class_decoder: combinational opcode/funct3 -> {is_addi, is_load, is_store, is_bne, is_illegal}. It is instantiated by multicycle_ctrl.

Test Plan:
- Reset held 3 cycles mid-MEM_RD (ack pending) -> all outputs 0 during reset. After release: FETCH, mem_req=1, addr_sel=0, instret=0.
- addi x1,x0,5 (0x00500093), zero-wait ack -> exactly 4 cycles FETCH->WB_ALU. alu_ctrl=SUM_OP, imm_src=Imm, reg_write=1 for 1 cycle, instret=1.
- lw x2,4(x0) (0x00402103) with ack delayed 3 cycles in MEM_RD -> mem_req/addr_sel=1 stable 4 cycles. Then WB_MEM with result_src=1, total 8 cycles.
- sw x2,8(x0) (0x00202423), then bne x1,x0,-8 (0xFE009CE3) with zero=0, then again with zero=1:
  - sw: imm_src=Store, mem_we=1.
  - bne, zero=0: pc_write=1, pc_src=1.
  - bne, zero=1: pc_write=0.
  - Each bne retires once.
- Illegal 0x00000033, and addi with funct3=001 -> HALT, illegal=1 held 20 cycles. No mem_req and no retire until rst.
- Preload instret near 0xFFFFFFFF via 2^32-2 forced retires, or a bench-forced counter value, then two addi -> instret reads 0xFFFFFFFF then 0x00000000.
